// File: rtl/pulse_period_meter_if.sv
// Periodic-pulse receive interface.
//   pulse_in      pulse train into the meter, synchronous to clk
//   period        last measured period in clk cycles (WIDTH+1 bits)
//   period_valid  1-cycle strobe: period updated
//   locked        period stable for the configured number of matches
//   timeout       1-cycle strobe: pulse train lost
// master = pulse source / result consumer, slave = the meter.
interface pulse_period_meter_if #(
    parameter int WIDTH = 4
);
    localparam int PW = WIDTH + 1;

    logic          pulse_in;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          timeout;

    modport master (
        output pulse_in,
        input  period, period_valid, locked, timeout
    );

    modport slave (
        input  pulse_in,
        output period, period_valid, locked, timeout
    );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between successive rising edges of a pulse train,
// reports each period with a 1-cycle strobe, declares lock once LOCK_COUNT
// consecutive periods match the previous one, and strobes timeout when no
// edge arrives within MAX = 2^(WIDTH+1)-1 cycles.
//   clk   clock, all logic on posedge
//   rst   synchronous, active-high reset
//   bus   slave side of pulse_period_meter_if (pulse_in in; period,
//         period_valid, locked, timeout out)
module pulse_period_meter #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_period_meter_if.slave   bus
);
    localparam int            PW  = WIDTH + 1;
    localparam logic [PW-1:0] MAX = '1;
    localparam int            MW  = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic          pulse_q, pulse_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] period_q, period_d;
    logic          valid_q, valid_d;
    logic          locked_q, locked_d;
    logic          timeout_q, timeout_d;
    logic [MW-1:0] match_q, match_d;
    // Set on arming: the first period after IDLE has no predecessor to match.
    logic          first_q, first_d;
    logic          edge_det;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            match_q   <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            match_q   <= match_d;
            first_q   <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pulse_d   = bus.pulse_in;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = 1'b0;
        match_d   = match_q;
        first_d   = first_q;
        edge_det  = bus.pulse_in & ~pulse_q;

        case (state_q)
            IDLE: begin
                if (edge_det) begin
                    cnt_d   = {{(PW-1){1'b0}}, 1'b1};
                    first_d = 1'b1;
                    match_d = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                // An edge on the cnt==MAX cycle is a valid measurement, so
                // the edge test comes before the timeout test.
                if (edge_det) begin
                    cnt_d    = {{(PW-1){1'b0}}, 1'b1};
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    first_d  = 1'b0;
                    if (!first_q && cnt_q == period_q) begin
                        if (match_q != LOCK_N)
                            match_d = match_q + 1'b1;
                    end else begin
                        match_d = '0;
                    end
                    if (match_d == LOCK_N) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d  = MEASURE;
                        locked_d = 1'b0;
                    end
                end else if (cnt_q == MAX) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
module tb_pulse_period_meter;
    localparam int WIDTH = 4;
    localparam int LOCK_COUNT = 2;
    localparam int MAXP = (1 << (WIDTH + 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        bit is_to;
        int per;
        bit lk;
        int at;
    } ev_t;
    ev_t sb[$];

    // Reference model state: edges and timing in absolute sample indices.
    bit prev_pin;
    bit armed;
    int last_edge;
    bit have_prev;
    int prev_p;
    int runlen;

    pulse_period_meter_if #(.WIDTH(WIDTH)) bus_if ();

    pulse_period_meter #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes an output.
    always @(negedge clk) begin
        if (bus_if.period_valid || bus_if.timeout) begin
            ev_t e;
            if (bus_if.period_valid && bus_if.timeout)
                chk("valid_and_timeout", 1, 0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("event_kind",  int'(bus_if.timeout), int'(e.is_to));
                chk("event_cycle", cyc, e.at);
                chk("locked",      int'(bus_if.locked), int'(e.lk));
                if (!e.is_to)
                    chk("period", int'(bus_if.period), e.per);
            end
        end
    end

    // Drive one sample of pulse_in and predict what the meter reports for it.
    task automatic step(input bit v);
        int k;
        ev_t e;
        k = cyc;
        bus_if.pulse_in = v;
        if (v && !prev_pin) begin
            if (armed) begin
                e.is_to = 1'b0;
                e.per = k - last_edge;
                if (have_prev && e.per == prev_p) runlen++;
                else runlen = 1;
                prev_p = e.per;
                have_prev = 1'b1;
                e.lk = (runlen > LOCK_COUNT);
                e.at = k + 1;
                sb.push_back(e);
            end else begin
                armed = 1'b1;
                have_prev = 1'b0;
                runlen = 0;
            end
            last_edge = k;
        end else if (armed && (k - last_edge) == MAXP) begin
            e.is_to = 1'b1;
            e.per = 0;
            e.lk = 1'b0;
            e.at = k + 1;
            sb.push_back(e);
            armed = 1'b0;
        end
        prev_pin = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.pulse_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_pin = 1'b0;
        armed = 1'b0;
        have_prev = 1'b0;
        runlen = 0;
        chk("rst_period", int'(bus_if.period), 0);
        chk("rst_valid",  int'(bus_if.period_valid), 0);
        chk("rst_locked", int'(bus_if.locked), 0);
        chk("rst_timeout", int'(bus_if.timeout), 0);
    endtask

    task automatic pulses(input int period, input int high, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < period; j++)
                step(j < high);
        end
    endtask

    initial begin
        bus_if.pulse_in = 1'b0;
        prev_pin = 1'b0;
        armed = 1'b0;
        have_prev = 1'b0;
        prev_p = 0;
        runlen = 0;
        last_edge = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        pulses(16, 1, 6);
        pulses(5, 1, 5);
        pulses(8, 3, 4);
        pulses(2, 1, 8);
        repeat (40) step(1'b0);
        pulses(31, 1, 4);
        pulses(16, 2, 5);
        repeat (7) step(1'b0);
        do_reset();
        pulses(6, 1, 4);
        repeat (35) step(1'b0);

        for (int s = 0; s < 40; s++) begin
            int p;
            p = $urandom_range(2, 40);
            if ($urandom_range(0, 9) == 0) do_reset();
            pulses(p, $urandom_range(1, p - 1), $urandom_range(1, 6));
        end

        repeat (40) step(1'b0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
